event_indicator: RTL and testbench

Output-side counterpart to the button synchronizer. It takes the single-cycle event pulses that the synchronizer produces and turns each one into a human-visible LED burst: LO is held high for ON_CYCLES, then a forced low gap of OFF_CYCLES. Events that arrive while a burst is in progress are queued in a saturating pending counter, so no press is visually lost until the queue saturates; a sticky overflow flag records any pulse that was dropped. It sits between the synchronized button/event strobes and the board LEDs.

---
 rtl/event_indicator.sv | 143 ++++++++++++++
 tb/tb_event_indicator.sv | 132 +++++++++++++
 2 files changed

// File: rtl/event_indicator.sv
// Stretches single-cycle event pulses into visible LED bursts (ON high, OFF low gap),
// queueing events that arrive mid-burst in a saturating counter with a sticky overflow flag.
module event_indicator #(
    parameter int ON_CYCLES  = 25_000_000,
    parameter int OFF_CYCLES = 12_500_000,
    parameter int MAX_PEND   = 7,
    localparam int PW        = $clog2(MAX_PEND + 1)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          PI,
    input  logic          CLR,
    output logic          LO,
    output logic          BUSY,
    output logic [PW-1:0] PEND,
    output logic          OVF
);

    localparam int CNT_MAX = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] ON_LOAD    = CW'(ON_CYCLES - 1);
    localparam logic [CW-1:0] OFF_LOAD   = CW'(OFF_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [PW-1:0] PEND_ZERO  = {PW{1'b0}};
    localparam logic [PW-1:0] PEND_ONE   = PW'(1);
    localparam logic [PW-1:0] PEND_MAX   = PW'(MAX_PEND);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ON   = 2'd1,
        ST_OFF  = 2'd2
    } state_t;

    state_t          state_r;
    logic [CW-1:0]   cnt_r;
    logic            lo_r;
    logic [PW-1:0]   pend_r;
    logic            ovf_r;

    logic            off_exit_s;
    logic            pend_nz_s;
    logic            inc_s;
    logic            dec_s;

    // Queue bookkeeping: a pulse landing on an empty-queue OFF exit starts the next burst directly.
    always_comb begin
        off_exit_s = 1'b0;
        pend_nz_s  = 1'b0;
        inc_s      = 1'b0;
        dec_s      = 1'b0;
        off_exit_s = (state_r == ST_OFF) && (cnt_r == CNT_ZERO);
        pend_nz_s  = (pend_r != PEND_ZERO);
        inc_s      = PI && (state_r != ST_IDLE) && !(off_exit_s && !pend_nz_s);
        dec_s      = off_exit_s && pend_nz_s;
    end

    // Burst sequencer: IDLE -> ON -> OFF, sharing one down-counter for both phases.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            lo_r    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (PI) begin
                        state_r <= ST_ON;
                        cnt_r   <= ON_LOAD;
                        lo_r    <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        cnt_r   <= CNT_ZERO;
                        lo_r    <= 1'b0;
                    end
                end
                ST_ON: begin
                    if (cnt_r == CNT_ZERO) begin
                        state_r <= ST_OFF;
                        cnt_r   <= OFF_LOAD;
                        lo_r    <= 1'b0;
                    end else begin
                        state_r <= ST_ON;
                        cnt_r   <= cnt_r - CNT_ONE;
                        lo_r    <= 1'b1;
                    end
                end
                ST_OFF: begin
                    if (cnt_r != CNT_ZERO) begin
                        state_r <= ST_OFF;
                        cnt_r   <= cnt_r - CNT_ONE;
                        lo_r    <= 1'b0;
                    end else if (pend_nz_s || PI) begin
                        state_r <= ST_ON;
                        cnt_r   <= ON_LOAD;
                        lo_r    <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        cnt_r   <= CNT_ZERO;
                        lo_r    <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= CNT_ZERO;
                    lo_r    <= 1'b0;
                end
            endcase
        end
    end

    // Pending counter and sticky overflow; CLR wins over any same-edge pulse.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pend_r <= PEND_ZERO;
            ovf_r  <= 1'b0;
        end else if (CLR) begin
            pend_r <= PEND_ZERO;
            ovf_r  <= 1'b0;
        end else if (inc_s && !dec_s) begin
            if (pend_r == PEND_MAX) begin
                pend_r <= pend_r;
                ovf_r  <= 1'b1;
            end else begin
                pend_r <= pend_r + PEND_ONE;
                ovf_r  <= ovf_r;
            end
        end else if (dec_s && !inc_s) begin
            pend_r <= pend_r - PEND_ONE;
            ovf_r  <= ovf_r;
        end else begin
            pend_r <= pend_r;
            ovf_r  <= ovf_r;
        end
    end

    assign LO   = lo_r;
    assign BUSY = (state_r != ST_IDLE);
    assign PEND = pend_r;
    assign OVF  = ovf_r;

endmodule

// File: tb/tb_event_indicator.sv
// Directed bench for event_indicator with ON=4, OFF=2, MAX_PEND=3; per-edge expectations
// are hand-written strings indexed by edge number (character k = value after edge k).
module tb_event_indicator;

    logic       CLK;
    logic       RST;
    logic       PI;
    logic       CLR;
    logic       LO;
    logic       BUSY;
    logic [1:0] PEND;
    logic       OVF;

    int num_checks;
    int num_failures;

    event_indicator #(
        .ON_CYCLES (4),
        .OFF_CYCLES(2),
        .MAX_PEND  (3)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .PI  (PI),
        .CLR (CLR),
        .LO  (LO),
        .BUSY(BUSY),
        .PEND(PEND),
        .OVF (OVF)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        num_checks++;
        if (obs !== exp) begin
            num_failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        PI  = 1'b0;
        CLR = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    // Drives pi_s/clr_s at edge k and checks outputs right after edge k.
    task automatic run_seq(input string tag, input string pi_s, input string clr_s,
                           input string lo_s, input string busy_s,
                           input string pend_s, input string ovf_s);
        for (int k = 0; k < pi_s.len(); k++) begin
            PI  = (pi_s[k] == "1");
            CLR = (clr_s.len() > k) ? (clr_s[k] == "1") : 1'b0;
            @(posedge CLK);
            #1;
            PI  = 1'b0;
            CLR = 1'b0;
            check_val($sformatf("%s_lo_e%0d", tag, k),   32'(LO),   32'(lo_s[k] - "0"));
            check_val($sformatf("%s_busy_e%0d", tag, k), 32'(BUSY), 32'(busy_s[k] - "0"));
            check_val($sformatf("%s_pend_e%0d", tag, k), 32'(PEND), 32'(pend_s[k] - "0"));
            check_val($sformatf("%s_ovf_e%0d", tag, k),  32'(OVF),  32'(ovf_s[k] - "0"));
        end
    endtask

    initial begin
        num_checks   = 0;
        num_failures = 0;
        RST = 1'b1;
        PI  = 1'b0;
        CLR = 1'b0;
        #2;
        check_val("rst_lo",   32'(LO),   32'd0);
        check_val("rst_busy", 32'(BUSY), 32'd0);
        check_val("rst_pend", 32'(PEND), 32'd0);
        check_val("rst_ovf",  32'(OVF),  32'd0);
        do_reset();

        run_seq("single", "10000000", "",
                "11110000", "11111100", "00000000", "00000000");
        do_reset();

        run_seq("three", "11100000000000000000", "",
                "11110011110011110000", "11111111111111111100",
                "01222211111100000000", "00000000000000000000");
        do_reset();

        run_seq("sat", "11111100000000000000000000", "",
                "11110011110011110011110000", "11111111111111111111111100",
                "01233322222211111100000000", "00001111111111111111111111");
        do_reset();

        run_seq("exit_q", "11000010000000000000", "",
                "11110011110011110000", "11111111111111111100",
                "01111111111100000000", "00000000000000000000");
        do_reset();

        run_seq("exit_e", "10000010000000", "",
                "11110011110000", "11111111111100",
                "00000000000000", "00000000000000");
        do_reset();

        run_seq("clr", "11111110000000", "00000001000000",
                "11110011110000", "11111111111100",
                "01233330000000", "00001110000000");
        do_reset();

        // Bring up a second burst mid-ON with OVF set, then assert RST between edges.
        run_seq("prerst", "11111000", "",
                "11110011", "11111111", "01233322", "00001111");
        #2;
        RST = 1'b1;
        #1;
        check_val("arst_lo",   32'(LO),   32'd0);
        check_val("arst_busy", 32'(BUSY), 32'd0);
        check_val("arst_pend", 32'(PEND), 32'd0);
        check_val("arst_ovf",  32'(OVF),  32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        run_seq("postrst", "10000000", "",
                "11110000", "11111100", "00000000", "00000000");

        $display("TB_RESULT checks=%0d failures=%0d", num_checks, num_failures);
        $finish;
    end

endmodule
